// File: rtl/loader_tx_if.sv
// Phit source handshake and control-plane write bus used by loader_tx.
// master = the loader itself, slave = the environment feeding and observing it.
interface loader_tx_if #(
    parameter int PHIT_W = 512
);
    logic [PHIT_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              start_loader;
    logic [PHIT_W-1:0] wr_data;

    modport master (
        input  src_data, src_valid,
        output src_ready, start_loader, wr_data
    );
    modport slave (
        output src_data, src_valid,
        input  src_ready, start_loader, wr_data
    );
endinterface

// File: rtl/loader_tx.sv
// Prefetching config loader: buffers phits, pulses start_loader, then streams TOTAL phits.
// Optional LOADER_TX_STATS_EN adds saturating load/underrun counters.
module loader_tx #(
    parameter int PHIT_W     = 512,
    parameter int NUM_COL    = 6,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_entry_state,
    input  logic [ADDR_W-1:0] num_entry_config_table,
    input  logic [ADDR_W-1:0] num_entry_inbound,
    loader_tx_if.master       bus,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef LOADER_TX_STATS_EN
    ,
    output logic [31:0]       load_cnt,
    output logic [31:0]       underrun_cnt
`endif
);
    localparam int TOT_W = ADDR_W + 4;
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PREFILL = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_GAP     = 3'd3;
    localparam logic [2:0] S_STREAM  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [TOT_W-1:0]  total_q, total_d;
    logic [TOT_W-1:0]  fetched_q, fetched_d;
    logic [TOT_W-1:0]  sent_q, sent_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              gap_cnt_q, gap_cnt_d;
    logic              urun_q, urun_d;
    logic              err_q, err_d;
    logic [PHIT_W-1:0] wr_data_q, wr_data_d;
    logic [PHIT_W-1:0] mem_q [FIFO_DEPTH];

    logic              push, pop, emit, fifo_full, fetching;
    logic [TOT_W-1:0]  total_calc, prefill_tgt;

    assign total_calc  = TOT_W'(num_entry_state)
                       + TOT_W'(NUM_COL) * TOT_W'(num_entry_config_table)
                       + TOT_W'(num_entry_inbound);
    assign prefill_tgt = (total_q >= TOT_W'(FIFO_DEPTH)) ? TOT_W'(FIFO_DEPTH) : total_q;
    assign fifo_full   = (count_q == (AW+1)'(FIFO_DEPTH));
    assign fetching    = (state_q != S_IDLE) && (state_q != S_DONE)
                       && !fifo_full && (fetched_q < total_q);
    assign push        = fetching && bus.src_valid;

    always_comb begin
        state_d   = state_q;
        total_d   = total_q;
        fetched_d = push ? fetched_q + TOT_W'(1) : fetched_q;
        sent_d    = sent_q;
        gap_cnt_d = gap_cnt_q;
        urun_d    = urun_q;
        err_d     = err_q;
        wr_data_d = '0;
        emit      = 1'b0;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    total_d   = total_calc;
                    fetched_d = '0;
                    sent_d    = '0;
                    urun_d    = 1'b0;
                    err_d     = 1'b0;
                    state_d   = S_PREFILL;
                end
            end
            S_PREFILL: begin
                if (TOT_W'(count_q) == prefill_tgt) state_d = S_START;
            end
            S_START: begin
                gap_cnt_d = 1'b1;
                state_d   = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_q) begin
                    gap_cnt_d = 1'b0;
                end else if (total_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_STREAM;
                    emit    = 1'b1;
                end
            end
            S_STREAM: begin
                if (urun_q) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (sent_q == total_q) begin
                    state_d = S_DONE;
                end else begin
                    emit = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // wr_data is loaded one edge ahead, so an empty FIFO here becomes a zero STREAM cycle
        if (emit) begin
            if (count_q != '0) begin
                pop       = 1'b1;
                wr_data_d = mem_q[rd_ptr_q];
                sent_d    = sent_q + TOT_W'(1);
            end else begin
                urun_d = 1'b1;
            end
        end

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        if (state_q == S_DONE) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            total_q   <= '0;
            fetched_q <= '0;
            sent_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            gap_cnt_q <= 1'b0;
            urun_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            total_q   <= total_d;
            fetched_q <= fetched_d;
            sent_q    <= sent_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            gap_cnt_q <= gap_cnt_d;
            urun_q    <= urun_d;
            err_q     <= err_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.src_data;
    end

    assign bus.src_ready    = fetching;
    assign bus.start_loader = (state_q == S_START);
    assign bus.wr_data      = wr_data_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign err              = err_q;

`ifdef LOADER_TX_STATS_EN
    logic [31:0] load_cnt_q, load_cnt_d;
    logic [31:0] underrun_cnt_q, underrun_cnt_d;

    always_comb begin
        load_cnt_d     = load_cnt_q;
        underrun_cnt_d = underrun_cnt_q;
        if (state_q == S_DONE) begin
            if (err_q) begin
                if (underrun_cnt_q != '1) underrun_cnt_d = underrun_cnt_q + 32'd1;
            end else if (load_cnt_q != '1) begin
                load_cnt_d = load_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt_q     <= '0;
            underrun_cnt_q <= '0;
        end else begin
            load_cnt_q     <= load_cnt_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign load_cnt     = load_cnt_q;
    assign underrun_cnt = underrun_cnt_q;
`endif
endmodule

// File: tb/tb_loader_tx.sv
// Directed bench for loader_tx: runs whole loads and checks timing, order, underrun and reset.
module tb_loader_tx;
    localparam int PHIT_W = 512;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] num_entry_state, num_entry_config_table, num_entry_inbound;
    logic              busy, done, err;
`ifdef LOADER_TX_STATS_EN
    logic [31:0]       load_cnt, underrun_cnt;
`endif

    loader_tx_if #(.PHIT_W(PHIT_W)) bus ();

    loader_tx #(.PHIT_W(PHIT_W), .NUM_COL(6), .ADDR_W(ADDR_W), .FIFO_DEPTH(16)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .start                  (start),
        .num_entry_state        (num_entry_state),
        .num_entry_config_table (num_entry_config_table),
        .num_entry_inbound      (num_entry_inbound),
        .bus                    (bus),
        .busy                   (busy),
        .done                   (done),
        .err                    (err)
`ifdef LOADER_TX_STATS_EN
        ,
        .load_cnt               (load_cnt),
        .underrun_cnt           (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total_chk = 0;
    int bad_chk   = 0;

    int phit_no;
    int n_ph, ord_bad, sl_cnt, sl_cyc, first_cyc, last_cyc;
    int done_cnt, done_cyc, err_done, rdy_seen, wr_bad, fetched, err_c0, err_c1;

    task automatic check_val(input string tag, input longint got, input longint exp);
        total_chk++;
        if (got !== exp) begin
            bad_chk++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_src(input int cyc, input int vmode, input int stop_ph);
        case (vmode)
            0:       bus.src_valid = 1'b1;
            1:       bus.src_valid = (cyc % 2 == 1);
            default: bus.src_valid = (phit_no < stop_ph);
        endcase
        bus.src_data = PHIT_W'(phit_no);
    endtask

    // vmode 0: always valid, 1: valid on odd cycles, 2: valid until phit stop_ph
    task automatic run(input int ns, input int nc, input int ni, input int vmode,
                       input int stop_ph, input int rst_at, input int restart_at);
        int  cyc;
        bit  xfer, fin, restarted;
        int  quiet_bad;
        n_ph = 0; ord_bad = 0; sl_cnt = 0; sl_cyc = -1; first_cyc = -1; last_cyc = -1;
        done_cnt = 0; done_cyc = -1; err_done = -1; rdy_seen = 0; wr_bad = 0; fetched = 0;
        err_c0 = -1; err_c1 = -1;
        restarted = 1'b0;
        @(posedge clk); #1;
        phit_no = 1;
        num_entry_state        = ADDR_W'(ns);
        num_entry_config_table = ADDR_W'(nc);
        num_entry_inbound      = ADDR_W'(ni);
        start = 1'b1;
        drive_src(0, vmode, stop_ph);
        cyc = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            if (cyc == 0) err_c0 = int'(err);
            if (cyc == 1) err_c1 = int'(err);
            if (bus.start_loader) begin
                sl_cnt++;
                if (sl_cyc < 0) sl_cyc = cyc;
            end
            if (bus.wr_data != '0) begin
                n_ph++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (bus.wr_data != PHIT_W'(n_ph)) ord_bad++;
                if (bus.start_loader || done || !busy) wr_bad++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                err_done = int'(err);
            end
            if (bus.src_ready) rdy_seen = 1;
            xfer = bus.src_valid && bus.src_ready;
            if (rst_at != 0 && n_ph == rst_at && bus.wr_data != '0) begin
                rst = 1'b1;
                #1;
                check_val("rst_busy", longint'(busy), 0);
                check_val("rst_done", longint'(done), 0);
                check_val("rst_err", longint'(err), 0);
                check_val("rst_start_loader", longint'(bus.start_loader), 0);
                check_val("rst_src_ready", longint'(bus.src_ready), 0);
                check_val("rst_wr_data_nonzero", longint'(bus.wr_data != '0), 0);
                start = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                quiet_bad = 0;
                repeat (6) begin
                    @(negedge clk);
                    if (done || busy || bus.wr_data != '0) quiet_bad++;
                end
                check_val("post_rst_quiet", quiet_bad, 0);
                fin = 1'b1;
            end else begin
                if (done_cnt > 0 && !busy) fin = 1'b1;
                if (!fin && cyc >= 400) begin
                    check_val("load_within_budget", 0, 1);
                    fin = 1'b1;
                end
                @(posedge clk); #1;
                start = 1'b0;
                if (xfer) begin
                    fetched++;
                    phit_no++;
                end
                cyc++;
                if (restart_at != 0 && !restarted && n_ph == restart_at) begin
                    restarted = 1'b1;
                    start = 1'b1;
                    num_entry_state        = '0;
                    num_entry_config_table = '0;
                    num_entry_inbound      = '0;
                end
                drive_src(cyc, vmode, stop_ph);
            end
        end
        start = 1'b0;
    endtask

    initial begin
`ifdef LOADER_TX_STATS_EN
        logic [31:0] lc_before;
`endif
        rst = 1'b1;
        start = 1'b0;
        num_entry_state = '0;
        num_entry_config_table = '0;
        num_entry_inbound = '0;
        bus.src_valid = 1'b0;
        bus.src_data = '0;
        phit_no = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_busy", longint'(busy), 0);
        check_val("reset_err", longint'(err), 0);
        check_val("reset_done", longint'(done), 0);
        check_val("reset_src_ready", longint'(bus.src_ready), 0);
        check_val("reset_start_loader", longint'(bus.start_loader), 0);
        @(posedge clk); #1 rst = 1'b0;

        // TOTAL = 2 + 6*2 + 16 = 30; prefill 16 phits -> start_loader 18 cycles after start
        run(2, 2, 16, 0, 0, 0, 0);
        check_val("t30_start_loader_cnt", sl_cnt, 1);
        check_val("t30_start_latency", sl_cyc, 18);
        check_val("t30_first_phit_delay", first_cyc - sl_cyc, 3);
        check_val("t30_phits", n_ph, 30);
        check_val("t30_order", ord_bad, 0);
        check_val("t30_contiguous", last_cyc - first_cyc, 29);
        check_val("t30_done_delay", done_cyc - last_cyc, 1);
        check_val("t30_done_cnt", done_cnt, 1);
        check_val("t30_err", err_done, 0);
        check_val("t30_wr_outside_stream", wr_bad, 0);
        check_val("t30_fetched", fetched, 30);

        // Empty load: START at cycle 2, two GAP cycles, DONE
        run(0, 0, 0, 0, 0, 0, 0);
        check_val("t0_start_loader_cnt", sl_cnt, 1);
        check_val("t0_start_latency", sl_cyc, 2);
        check_val("t0_done_delay", done_cyc - sl_cyc, 3);
        check_val("t0_phits", n_ph, 0);
        check_val("t0_src_ready_seen", rdy_seen, 0);
        check_val("t0_done_cnt", done_cnt, 1);

        // Source stalls from phit 20: 19 phits then underrun
        run(2, 2, 16, 2, 20, 0, 0);
        check_val("urun_phits", n_ph, 19);
        check_val("urun_order", ord_bad, 0);
        check_val("urun_done_cnt", done_cnt, 1);
        check_val("urun_err_at_done", err_done, 1);
        check_val("urun_wr_outside_stream", wr_bad, 0);
        check_val("urun_err_sticky", longint'(err), 1);

        // TOTAL = 1 + 6 + 4 = 11, source valid on odd cycles -> 11th push in cycle 21, START cycle 23
        run(1, 1, 4, 1, 0, 0, 0);
        check_val("slow_err_before_start", err_c0, 1);
        check_val("slow_err_cleared", err_c1, 0);
        check_val("slow_start_latency", sl_cyc, 23);
        check_val("slow_phits", n_ph, 11);
        check_val("slow_order", ord_bad, 0);
        check_val("slow_contiguous", last_cyc - first_cyc, 10);
        check_val("slow_fetched", fetched, 11);
        check_val("slow_err", err_done, 0);

        // Reset during the 5th STREAM cycle, then a clean load from phit 1
        run(2, 2, 16, 0, 0, 5, 0);
        check_val("rst_no_done", done_cnt, 0);
        run(2, 2, 16, 0, 0, 0, 0);
        check_val("after_rst_phits", n_ph, 30);
        check_val("after_rst_order", ord_bad, 0);
        check_val("after_rst_done_cnt", done_cnt, 1);

        // Start pulsed (with zero counts) mid-stream must be ignored
`ifdef LOADER_TX_STATS_EN
        lc_before = load_cnt;
`endif
        run(1, 1, 4, 0, 0, 0, 3);
        check_val("restart_start_loader_cnt", sl_cnt, 1);
        check_val("restart_phits", n_ph, 11);
        check_val("restart_order", ord_bad, 0);
        check_val("restart_done_cnt", done_cnt, 1);
`ifdef LOADER_TX_STATS_EN
        check_val("restart_load_cnt_delta", longint'(load_cnt - lc_before), 1);
        check_val("underrun_cnt", longint'(underrun_cnt), 0);
`endif

        // Largest counts: TOTAL = 31 + 6*31 + 31 = 248
        run(31, 31, 31, 0, 0, 0, 0);
        check_val("max_phits", n_ph, 248);
        check_val("max_order", ord_bad, 0);
        check_val("max_fetched", fetched, 248);
        check_val("max_contiguous", last_cyc - first_cyc, 247);

        $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
        $finish;
    end
endmodule
